rms_norm_stream: RTL
====================

# rms_norm_stream

Streaming RMS normalisation with per-element scaling for vectors longer than one datapath word. Accepts a D-element vector as NUM_CHUNKS consecutive ARR_WIDTH-wide chunks over a valid/ready handshake and buffers them. It computes the reciprocal RMS with sequential square-root and divide units, then emits the normalised, optionally scaled chunks over a second valid/ready handshake. It sits between the token-mixer output and the next ternary linear layer, replacing the single-word normaliser.

## Interface
- ARR_WIDTH, 8: elements per chunk.
- FXP_N, 16: signed fixed-point element width.
- FXP_FRAC, 8: fraction bits (F).
- NUM_CHUNKS, 4: chunks per vector. D = ARR_WIDTH*NUM_CHUNKS must be a power of two (elaboration error otherwise).
- EPS, 1: epsilon added to the mean square, in Q(2F) LSBs. Must be ≥1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input chunk valid.
- in_ready  out  1  high only in IDLE/ACCUM.
- input_arr  in  ARR_WIDTH×FXP_N signed  input chunk.
- scaling_arr  in  ARR_WIDTH×FXP_N signed  gamma chunk, paired with input_arr.
- out_valid  out  1  output chunk valid.
- out_ready  in  1  downstream accept.
- output_arr  out  ARR_WIDTH×FXP_N signed  result chunk.
- done  out  1  one-cycle pulse on last output handshake.

## Operation
- States: IDLE → ACCUM → SQRT → RECIP → EMIT → IDLE.
- IDLE/ACCUM: each in_valid&in_ready beat stores the chunk (and gamma) at the chunk counter index. It adds Σx² into acc, where x² is in Q(2F) and ACC_W = 2·FXP_N + log2(D), rounded up to even. The first beat leaves IDLE. The NUM_CHUNKS-th beat enters SQRT; in_ready drops the following cycle.
- SQRT: ms = (acc >> log2(D)) + EPS. It computes rms = floor(isqrt(ms)) by restoring bit-serial square root, one result bit per cycle, ACC_W/2 cycles. Result is Q F; rms ≥ 1 always.
- RECIP: inv = floor(2^(2F) / rms) by restoring division, FXP_N cycles. It saturates to 2^(FXP_N-1)−1 if the quotient overflows.
- EMIT: chunk k from buffer. Per element, y = sat((x·inv) >>> F). With scaling, z = sat((y·g) >>> F). Shifts are arithmetic (truncate toward −∞). sat clamps to [−2^(FXP_N-1), 2^(FXP_N-1)−1]. Elements are computed combinationally from the buffer and inv.
- output_arr is held stable while out_valid && !out_ready. The chunk index advances only on handshake. The last handshake pulses done and returns to IDLE, with acc and counters cleared.
- A new vector cannot be accepted until EMIT completes; there is no overlap.

## Timing
- Reset: in_ready=1, out_valid=0, done=0, output_arr=0, state IDLE, counters/acc/inv=0. Buffer contents are don't-care.
- Reset asserted mid-operation aborts immediately; partial vector is discarded; no done.
- Latency from last input handshake to first out_valid: 1 + ACC_W/2 + FXP_N cycles.
- With out_ready held high, output beats are back-to-back: NUM_CHUNKS consecutive cycles. done is coincident with the last beat.
- in_valid gaps during ACCUM are allowed: state and acc hold.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.

## Configuration
- RMS_SCALE_EN defined: gamma is buffered and the multiply is applied; output = z.
- RMS_SCALE_EN undefined: scaling_arr is ignored and not buffered; output = y (gamma treated as 1.0). Latency is unchanged.

## Test plan
- FXP_N=16, F=8, ARR_WIDTH=4, NUM_CHUNKS=2, gamma=1.0 (256):
- All x=256 (1.0) → ms=65537, rms=256, inv=256; every output 256. done pulses once, on the 2nd output beat. First out_valid at 1+ACC_W/2+16 cycles after the last input beat.
- All x=512 → inv=128; outputs 256. All x=−512 → outputs −256 (sign and arithmetic-shift check).
- All x=0 → rms=1, inv saturates to 32767; outputs 0. Separately, with x=1 in element 0 and 0 elsewhere: ms=1, inv=32767, y[0]=127, others 0.
- x=256, gamma=128 (0.5) → outputs 128 with RMS_SCALE_EN; 256 without.
- Backpressure: out_ready low for 5 cycles on beat 0 → output_arr is stable, out_valid stays high, and no beat is lost. Random in_valid gaps give identical results.
- rst_n pulsed during SQRT → out_valid=0, in_ready=1 next cycle. The following clean vector produces correct results.

Source files
------------

// File: rtl/rms_norm_stream.sv
// Streaming RMS normaliser: buffers NUM_CHUNKS chunks, derives 1/rms with a bit-serial sqrt and divider, then streams results.
// Define RMS_SCALE_EN to buffer gamma and apply the per-element scaling multiply.
module rms_norm_stream #(
  parameter int ARR_WIDTH  = 8,
  parameter int FXP_N      = 16,
  parameter int FXP_FRAC   = 8,
  parameter int NUM_CHUNKS = 4,
  parameter int EPS        = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ARR_WIDTH*FXP_N-1:0] input_arr,
  input  logic [ARR_WIDTH*FXP_N-1:0] scaling_arr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ARR_WIDTH*FXP_N-1:0] output_arr,
  output logic                       done
);
  localparam int VEC_W   = ARR_WIDTH * FXP_N;
  localparam int D       = ARR_WIDTH * NUM_CHUNKS;
  localparam int LOG2D   = $clog2(D);
  localparam int ACC_RAW = 2 * FXP_N + LOG2D;
  localparam int ACC_W   = ACC_RAW + (ACC_RAW % 2);
  localparam int H       = ACC_W / 2;
  localparam int CNT_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int STEP_W  = $clog2((H > FXP_N) ? H : FXP_N) + 1;
  localparam int DVD_W   = 2 * FXP_FRAC + FXP_N + 1;

  localparam logic [DVD_W-1:0]         DIVIDEND   = {{(DVD_W-1){1'b0}}, 1'b1} << (2 * FXP_FRAC);
  localparam logic [DVD_W-1:0]         DVD_HI     = DIVIDEND >> FXP_N;
  localparam logic [FXP_N-1:0]         DVD_LO     = DIVIDEND[FXP_N-1:0];
  localparam logic [FXP_N-1:0]         INV_MAX    = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic signed [2*FXP_N-1:0] SAT_HI    = {{(FXP_N+1){1'b0}}, {(FXP_N-1){1'b1}}};
  localparam logic signed [2*FXP_N-1:0] SAT_LO    = {{(FXP_N+1){1'b1}}, {(FXP_N-1){1'b0}}};
  localparam logic [CNT_W-1:0]         LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [STEP_W-1:0]        LAST_SQRT  = STEP_W'(H - 1);
  localparam logic [STEP_W-1:0]        LAST_DIV   = STEP_W'(FXP_N - 1);

  if ((D & (D - 1)) != 0) begin : g_bad_d
    $error("rms_norm_stream: ARR_WIDTH*NUM_CHUNKS must be a power of two");
  end
  if (EPS < 1) begin : g_bad_eps
    $error("rms_norm_stream: EPS must be at least 1");
  end

  function automatic logic [FXP_N-1:0] sat_shift(input logic signed [2*FXP_N-1:0] p);
    logic signed [2*FXP_N-1:0] s;
    s = p >>> FXP_FRAC;
    if (s > SAT_HI)      return SAT_HI[FXP_N-1:0];
    else if (s < SAT_LO) return SAT_LO[FXP_N-1:0];
    else                 return s[FXP_N-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] sum_sq(input logic [VEC_W-1:0] v);
    logic signed [FXP_N-1:0]   e;
    logic signed [2*FXP_N-1:0] p;
    logic [ACC_W-1:0]          s;
    s = '0;
    for (int i = 0; i < ARR_WIDTH; i++) begin
      e = v[i*FXP_N +: FXP_N];
      p = (2*FXP_N)'(e) * (2*FXP_N)'(e);
      s = s + ACC_W'($unsigned(p));
    end
    return s;
  endfunction

  function automatic logic [VEC_W-1:0] norm_chunk(input logic [VEC_W-1:0] x, input logic [FXP_N-1:0] inv);
    logic signed [FXP_N-1:0]   xe;
    logic signed [2*FXP_N-1:0] p;
    logic [VEC_W-1:0]          r;
    r = '0;
    for (int i = 0; i < ARR_WIDTH; i++) begin
      xe = x[i*FXP_N +: FXP_N];
      p  = (2*FXP_N)'(xe) * (2*FXP_N)'($signed(inv));
      r[i*FXP_N +: FXP_N] = sat_shift(p);
    end
    return r;
  endfunction

`ifdef RMS_SCALE_EN
  function automatic logic [VEC_W-1:0] apply_gamma(input logic [VEC_W-1:0] y, input logic [VEC_W-1:0] g);
    logic signed [FXP_N-1:0]   ye;
    logic signed [FXP_N-1:0]   ge;
    logic signed [2*FXP_N-1:0] p;
    logic [VEC_W-1:0]          r;
    r = '0;
    for (int i = 0; i < ARR_WIDTH; i++) begin
      ye = y[i*FXP_N +: FXP_N];
      ge = g[i*FXP_N +: FXP_N];
      p  = (2*FXP_N)'(ye) * (2*FXP_N)'(ge);
      r[i*FXP_N +: FXP_N] = sat_shift(p);
    end
    return r;
  endfunction
`endif

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SQRT, S_RECIP, S_EMIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    chunk_q, chunk_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ACC_W-1:0]    acc_q, acc_d, rad_q, rad_d;
  logic [H-1:0]        srem_q, srem_d, root_q, root_d, drem_q, drem_d;
  logic [FXP_N-1:0]    quot_q, quot_d, inv_q, inv_d;
  logic                ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [VEC_W-1:0]    out_arr_q, out_arr_d;
  logic [VEC_W-1:0]    buf_x_q [NUM_CHUNKS];
  logic [VEC_W-1:0]    buf_x_d [NUM_CHUNKS];
`ifdef RMS_SCALE_EN
  logic [VEC_W-1:0]    buf_g_q [NUM_CHUNKS];
  logic [VEC_W-1:0]    buf_g_d [NUM_CHUNKS];
`else
  logic                unused_scaling_s;
  assign unused_scaling_s = ^scaling_arr;
`endif

  logic [ACC_W-1:0]    ms_s, rad_src_s;
  logic [H-1:0]        srem_src_s, root_src_s, drem_src_s;
  logic [H+1:0]        srem_sh_s, trial_s;
  logic [H:0]          dshift_s;
  logic [FXP_N-1:0]    dlo_s, qfin_s;
  logic                sq_ge_s, qbit_s, ovf_now_s, ovf_any_s, done_s;
  logic [CNT_W-1:0]    emit_idx_s;
  logic [VEC_W-1:0]    emit_arr_s;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid  = out_valid_q;
  assign output_arr = out_arr_q;
  assign done       = done_s;

  // One sqrt / divide iteration; step 0 seeds the radicand from acc and the remainder from the dividend's high part.
  always_comb begin
    ms_s       = (acc_q >> LOG2D) + ACC_W'(EPS);
    rad_src_s  = (step_q == '0) ? ms_s : rad_q;
    srem_src_s = (step_q == '0) ? '0 : srem_q;
    root_src_s = (step_q == '0) ? '0 : root_q;
    srem_sh_s  = {srem_src_s, rad_src_s[ACC_W-1 -: 2]};
    trial_s    = {root_src_s, 2'b01};
    sq_ge_s    = (srem_sh_s >= trial_s);
    ovf_now_s  = (DVD_HI >= DVD_W'(root_q));
    drem_src_s = (step_q == '0) ? H'(DVD_HI) : drem_q;
    dlo_s      = DVD_LO << step_q;
    dshift_s   = {drem_src_s, dlo_s[FXP_N-1]};
    qbit_s     = (dshift_s >= {1'b0, root_q});
    qfin_s     = (quot_q << 1) | FXP_N'(qbit_s);
    ovf_any_s  = ovf_q | ((step_q == '0) & ovf_now_s);
  end

  // Chunk to present next: the current index on EMIT entry, the following one after a handshake.
  always_comb begin
    if (out_valid_q && (chunk_q != LAST_CHUNK)) emit_idx_s = chunk_q + CNT_W'(1);
    else                                        emit_idx_s = chunk_q;
    emit_arr_s = norm_chunk(buf_x_q[emit_idx_s], inv_q);
`ifdef RMS_SCALE_EN
    emit_arr_s = apply_gamma(emit_arr_s, buf_g_q[emit_idx_s]);
`endif
  end

  // Control FSM and next-state for all registered state.
  always_comb begin
    state_d = state_q;  chunk_d = chunk_q;  step_d = step_q;  acc_d = acc_q;
    rad_d = rad_q;  srem_d = srem_q;  root_d = root_q;  drem_d = drem_q;
    quot_d = quot_q;  ovf_d = ovf_q;  inv_d = inv_q;
    out_valid_d = out_valid_q;  out_arr_d = out_arr_q;  done_s = 1'b0;
    buf_x_d = buf_x_q;
`ifdef RMS_SCALE_EN
    buf_g_d = buf_g_q;
`endif
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (in_valid) begin
          buf_x_d[chunk_q] = input_arr;
`ifdef RMS_SCALE_EN
          buf_g_d[chunk_q] = scaling_arr;
`endif
          acc_d = acc_q + sum_sq(input_arr);
          if (chunk_q == LAST_CHUNK) begin
            state_d = S_SQRT;
            chunk_d = '0;
            step_d  = '0;
          end else begin
            state_d = S_ACCUM;
            chunk_d = chunk_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      S_SQRT: begin
        rad_d  = rad_src_s << 2;
        srem_d = sq_ge_s ? H'(srem_sh_s - trial_s) : H'(srem_sh_s);
        root_d = {root_src_s[H-2:0], sq_ge_s};
        if (step_q == LAST_SQRT) begin
          state_d = S_RECIP;
          step_d  = '0;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end
      S_RECIP: begin
        drem_d = qbit_s ? H'(dshift_s - {1'b0, root_q}) : H'(dshift_s);
        quot_d = qfin_s;
        ovf_d  = ovf_any_s;
        if (step_q == LAST_DIV) begin
          inv_d   = (ovf_any_s || qfin_s[FXP_N-1]) ? INV_MAX : qfin_s;
          state_d = S_EMIT;
          step_d  = '0;
        end else begin
          step_d  = step_q + STEP_W'(1);
        end
      end
      S_EMIT: begin
        if (!out_valid_q) begin
          out_arr_d   = emit_arr_s;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (chunk_q == LAST_CHUNK) begin
            done_s      = 1'b1;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
            chunk_d     = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            chunk_d     = chunk_q + CNT_W'(1);
            out_arr_d   = emit_arr_s;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and arithmetic state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  chunk_q <= '0;  step_q <= '0;  acc_q <= '0;
      rad_q <= '0;  srem_q <= '0;  root_q <= '0;  drem_q <= '0;
      quot_q <= '0;  ovf_q <= 1'b0;  inv_q <= '0;
      out_valid_q <= 1'b0;  out_arr_q <= '0;
    end else begin
      state_q <= state_d;  chunk_q <= chunk_d;  step_q <= step_d;  acc_q <= acc_d;
      rad_q <= rad_d;  srem_q <= srem_d;  root_q <= root_d;  drem_q <= drem_d;
      quot_q <= quot_d;  ovf_q <= ovf_d;  inv_q <= inv_d;
      out_valid_q <= out_valid_d;  out_arr_q <= out_arr_d;
    end
  end

  // Vector buffer; contents are only meaningful once a full vector has been accepted.
  always_ff @(posedge clk) begin
    buf_x_q <= buf_x_d;
`ifdef RMS_SCALE_EN
    buf_g_q <= buf_g_d;
`endif
  end
endmodule
